// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator that drives a single-port data memory for the MEM stage.
// Define LSU_SUBWORD_EN to enable byte/half accesses (read-modify-write stores, extended loads).
module lsu_mem_ctrl #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] data_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] data_in_q, data_in_d;
    logic        accept;

    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
`ifdef LSU_SUBWORD_EN
        case (size)
            2'b01:   req_bad = lane[0];
            2'b10:   req_bad = (lane != 2'b00);
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
`else
        req_bad = (size != 2'b10) || (lane != 2'b00);
`endif
    endfunction

`ifdef LSU_SUBWORD_EN
    logic        we_q, we_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;

    // Replace only the addressed byte/half of the old word.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_word, input logic [15:0] wd,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old_word;
        if (size == 2'b00)
            r[{lane, 3'b000} +: 8] = wd[7:0];
        else
            r[{lane[1], 4'b0000} +: 16] = wd;
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction
`else
    logic unused_signed;
    assign unused_signed = req_signed;
`endif

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        resp_rdata_d  = resp_rdata_q;
        mem_address_d = mem_address_q;
        data_in_d     = data_in_q;
`ifdef LSU_SUBWORD_EN
        we_d    = we_q;
        sgn_d   = sgn_q;
        size_d  = size_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_address_d = {2'b00, req_addr[31:2]};
                    err_d         = 1'b0;
`ifdef LSU_SUBWORD_EN
                    we_d    = req_we;
                    sgn_d   = req_signed;
                    size_d  = req_size;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
`endif
                    if (req_bad(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        data_in_d = req_wdata;
                        state_d   = WRITE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
`ifdef LSU_SUBWORD_EN
                    if (we_q) begin
                        data_in_d = merge_lane(data_out, wdata_q, size_q, lane_q);
                        state_d   = WRITE;
                    end else begin
                        resp_rdata_d = extend_load(data_out, size_q, lane_q, sgn_q);
                        state_d      = RESP;
                    end
`else
                    resp_rdata_d = data_out;
                    state_d      = RESP;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            resp_rdata_q  <= '0;
            mem_address_q <= '0;
            data_in_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            resp_rdata_q  <= resp_rdata_d;
            mem_address_q <= mem_address_d;
            data_in_q     <= data_in_d;
        end
    end

`ifdef LSU_SUBWORD_EN
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        sgn_q   <= sgn_d;
        size_q  <= size_d;
        lane_q  <= lane_d;
        wdata_q <= wdata_d;
    end
`endif

    // Strobes decode straight from state so an async reset drops them immediately.
    assign req_ready   = (state_q == IDLE);
    assign mem_read    = (state_q == READ);
    assign mem_write   = (state_q == WRITE);
    assign resp_valid  = (state_q == RESP);
    assign resp_err    = (state_q == RESP) && err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign data_in     = data_in_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: one instance at READ_LATENCY=1, one at 3.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v1 = 1'b0, v3 = 1'b0;
    logic        we = 1'b0, sgn = 1'b0;
    logic [1:0]  sz = 2'b10;
    logic [31:0] addr = '0, wdata = '0, mem_rd = '0;

    logic        rdy1, rv1, re1, mr1, mw1;
    logic [31:0] rd1, ma1, di1;
    logic        rdy3, rv3, re3, mr3, mw3;
    logic [31:0] rd3, ma3, di3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we), .req_size(sz),
        .req_signed(sgn), .req_addr(addr), .req_wdata(wdata), .resp_valid(rv1), .resp_err(re1),
        .resp_rdata(rd1), .mem_address(ma1), .data_in(di1), .mem_read(mr1), .mem_write(mw1),
        .data_out(mem_rd)
    );

    lsu_mem_ctrl #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we), .req_size(sz),
        .req_signed(sgn), .req_addr(addr), .req_wdata(wdata), .resp_valid(rv3), .resp_err(re3),
        .resp_rdata(rd3), .mem_address(ma3), .data_in(di3), .mem_read(mr3), .mem_write(mw3),
        .data_out(mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in cycle 1.
    task automatic issue(input logic to3, input logic w, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        we = w; sz = s; sgn = sg; addr = a; wdata = d;
        if (to3) v3 = 1'b1; else v1 = 1'b1;
        tick();
        v1 = 1'b0; v3 = 1'b0;
        addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF; sz = 2'b11; we = ~w;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk("rst_ready", rdy1, 1'b1);
        chk("rst_rv", rv1, 1'b0);
        chk("rst_err", re1, 1'b0);
        chk("rst_mr", mr1, 1'b0);
        chk("rst_mw", mw1, 1'b0);
        chk("rst_rdata", rd1, 32'h0);
        chk("rst_addr", ma1, 32'h0);
        chk("rst_din", di1, 32'h0);
        tick();
        rst = 1'b0;

        // word store 0x14 <- 10
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'd10);
        chk("ws_c1_mw", mw1, 1'b1);
        chk("ws_c1_mr", mr1, 1'b0);
        chk("ws_c1_addr", ma1, 32'd5);
        chk("ws_c1_din", di1, 32'd10);
        chk("ws_c1_rv", rv1, 1'b0);
        chk("ws_c1_ready", rdy1, 1'b0);
        tick();
        chk("ws_c2_rv", rv1, 1'b1);
        chk("ws_c2_err", re1, 1'b0);
        chk("ws_c2_mw", mw1, 1'b0);
        chk("ws_c2_rdata", rd1, 32'h0);
        tick();
        chk("ws_c3_ready", rdy1, 1'b1);
        chk("ws_c3_rv", rv1, 1'b0);

        // word load 0x14, memory returns 10
        mem_rd = 32'd10;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("wl_c1_mr", mr1, 1'b1);
        chk("wl_c1_addr", ma1, 32'd5);
        chk("wl_c1_rv", rv1, 1'b0);
        tick();
        chk("wl_c2_rv", rv1, 1'b1);
        chk("wl_c2_err", re1, 1'b0);
        chk("wl_c2_rdata", rd1, 32'd10);
        chk("wl_c2_mr", mr1, 1'b0);
        tick();
        chk("wl_c3_ready", rdy1, 1'b1);

        // second word load back-to-back with new data
        mem_rd = 32'hDEAD_BEEF;
        issue(1'b0, 1'b0, 2'b10, 1'b1, 32'h8, 32'h0);
        chk("wl2_c1_addr", ma1, 32'd2);
        tick();
        chk("wl2_c2_rdata", rd1, 32'hDEAD_BEEF);
        tick();

        // byte store 0xAA to 0x1E over word 0x11223344
        mem_rd = 32'h1122_3344;
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h1E, 32'h5555_55AA);
`ifdef LSU_SUBWORD_EN
        chk("bs_c1_mr", mr1, 1'b1);
        chk("bs_c1_addr", ma1, 32'd7);
        chk("bs_c1_mw", mw1, 1'b0);
        tick();
        chk("bs_c2_mw", mw1, 1'b1);
        chk("bs_c2_mr", mr1, 1'b0);
        chk("bs_c2_din", di1, 32'h11AA_3344);
        chk("bs_c2_addr", ma1, 32'd7);
        tick();
        chk("bs_c3_rv", rv1, 1'b1);
        chk("bs_c3_err", re1, 1'b0);
        chk("bs_c3_rdata", rd1, 32'hDEAD_BEEF);
        tick();

        // half store 0xBEEF at offset 2
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h1E, 32'h1234_BEEF);
        tick();
        chk("hs_c2_din", di1, 32'hBEEF_3344);
        tick();
        tick();

        // half loads, signed and unsigned
        mem_rd = 32'h0000_F080;
        issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        tick();
        chk("hl_s_rv", rv1, 1'b1);
        chk("hl_s_rdata", rd1, 32'hFFFF_F080);
        tick();
        issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        tick();
        chk("hl_u_rdata", rd1, 32'h0000_F080);
        tick();

        // signed byte load from lane 3
        mem_rd = 32'h8012_3456;
        issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        tick();
        chk("bl_s_rdata", rd1, 32'hFFFF_FF80);
        tick();
`else
        chk("bs_err_rv", rv1, 1'b1);
        chk("bs_err_err", re1, 1'b1);
        chk("bs_err_mr", mr1, 1'b0);
        chk("bs_err_mw", mw1, 1'b0);
        tick();
        chk("bs_err_ready", rdy1, 1'b1);
        issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        chk("hl_err_err", re1, 1'b1);
        chk("hl_err_mr", mr1, 1'b0);
        tick();
        chk("hl_err_rdata", rd1, 32'hDEAD_BEEF);
`endif

        // misaligned word load 0x15
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h15, 32'h0);
        chk("mis_rv", rv1, 1'b1);
        chk("mis_err", re1, 1'b1);
        chk("mis_mr", mr1, 1'b0);
        chk("mis_mw", mw1, 1'b0);
        tick();
        chk("mis_c2_rv", rv1, 1'b0);
        chk("mis_c2_ready", rdy1, 1'b1);

        // illegal size and odd half address
        issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("ill_err", re1, 1'b1);
        chk("ill_mw", mw1, 1'b0);
        tick();
        issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        chk("odd_half_err", re1, 1'b1);
        tick();

        // L=3 word load
        mem_rd = 32'h1234_5678;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        chk("l3_c1_mr", mr3, 1'b1);
        chk("l3_c1_addr", ma3, 32'h10);
        tick();
        chk("l3_c2_mr", mr3, 1'b1);
        tick();
        chk("l3_c3_mr", mr3, 1'b1);
        chk("l3_c3_rv", rv3, 1'b0);
        tick();
        chk("l3_c4_rv", rv3, 1'b1);
        chk("l3_c4_mr", mr3, 1'b0);
        chk("l3_c4_rdata", rd3, 32'h1234_5678);
        tick();
        chk("l3_c5_ready", rdy3, 1'b1);

        // reset in cycle 2 of an in-flight access
        mem_rd = 32'h1122_3344;
`ifdef LSU_SUBWORD_EN
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h1E, 32'h0000_00AA);
`else
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0);
`endif
        chk("rm_c1_mr", mr3, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("rm_mr_drop", mr3, 1'b0);
        chk("rm_ready", rdy3, 1'b1);
        chk("rm_rv", rv3, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("rm_rdata_cleared", rd3, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("rm_no_mw", mw3, 1'b0);
            chk("rm_no_rv", rv3, 1'b0);
            tick();
        end
        chk("rm_idle_ready", rdy3, 1'b1);

        // normal operation after reset
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D);
        chk("post_mw", mw3, 1'b1);
        chk("post_din", di3, 32'hCAFE_F00D);
        chk("post_addr", ma3, 32'h11);
        tick();
        chk("post_rv", rv3, 1'b1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
